// File: rtl/wrapper_pkg.sv
// Shared types and default sizes for the multi-channel accelerator stream wrapper.
// Optional saturation is selected with the WRAPPER_SAT_EN macro (see power_unit).
package wrapper_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MUL   = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int CH_DEF     = 4;
  localparam int DATA_W_DEF = 16;
  localparam int UI_W_DEF   = 2;
  localparam int RES_W_DEF  = 21;

endpackage

// File: rtl/power_unit.sv
// Iterated-multiply power engine: acc = x^(p+1) via one multiply per step.
// WRAPPER_SAT_EN defined: sticky overflow clamps acc to all-ones; otherwise modular truncation.
module power_unit
  import wrapper_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int UI_W   = UI_W_DEF,
  parameter int RES_W  = RES_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] x,
  input  logic [UI_W-1:0]   p,
  output logic [RES_W-1:0]  acc,
  output logic              zero
);

  logic [RES_W-1:0] acc_q, acc_d;
  logic [UI_W-1:0]  cnt_q, cnt_d;

`ifdef WRAPPER_SAT_EN
  localparam int PW = RES_W + DATA_W;
  logic [PW-1:0] prod;
  logic          ovf_q, ovf_d;

  always_comb begin
    prod  = PW'(acc_q) * PW'(x);
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (load) begin
      acc_d = RES_W'(x);
      cnt_d = p;
      ovf_d = 1'b0;
    end else if (step) begin
      // Once any product bit spills past RES_W the channel stays pinned at full scale.
      ovf_d = ovf_q | (|prod[PW-1:RES_W]);
      acc_d = ovf_d ? '1 : prod[RES_W-1:0];
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_q <= 1'b0;
    else      ovf_q <= ovf_d;
  end
`else
  logic [RES_W-1:0] prod;

  always_comb begin
    prod  = acc_q * RES_W'(x);
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (load) begin
      acc_d = RES_W'(x);
      cnt_d = p;
    end else if (step) begin
      acc_d = prod;
      cnt_d = cnt_q - 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc = acc_q;
  // High when the step taken this cycle is the last one (count goes to zero).
  assign zero = (cnt_q == UI_W'(1));

endmodule

// File: rtl/accel_stream_wrapper.sv
// Multi-channel power accelerator: captures CH words on w_start, writes x_c^(ui_c+1) per channel.
// Write port: wr_req/wr_data/wr_ch hold stable until wr_ack is seen high at a clock edge while wr_req=1.
// WRAPPER_SAT_EN selects saturating results inside power_unit.
module accel_stream_wrapper
  import wrapper_pkg::*;
#(
  parameter int CH     = CH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int UI_W   = UI_W_DEF,
  parameter int RES_W  = RES_W_DEF,
  parameter int CH_W   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w_start,
  input  logic [CH*DATA_W-1:0] vi_bus,
  input  logic [CH*UI_W-1:0]   ui_bus,
  input  logic                 wr_ack,
  output logic                 wr_req,
  output logic [RES_W-1:0]     wr_data,
  output logic [CH_W-1:0]      wr_ch,
  output logic                 busy,
  output logic                 w_done,
  output state_t               dbg_state
);

  state_t               state_q, state_d;
  logic [CH_W-1:0]      c_q, c_d;
  logic [CH*DATA_W-1:0] x_q, x_d;
  logic [CH*UI_W-1:0]   ui_q, ui_d;
  logic                 wr_req_q, wr_req_d;
  logic                 busy_q, busy_d;
  logic                 w_done_q, w_done_d;

  logic                 load, step, zero;
  logic [DATA_W-1:0]    x_c;
  logic [UI_W-1:0]      ui_c;
  logic [RES_W-1:0]     acc;

  assign x_c  = x_q[c_q*DATA_W +: DATA_W];
  assign ui_c = ui_q[c_q*UI_W +: UI_W];

  power_unit #(.DATA_W(DATA_W), .UI_W(UI_W), .RES_W(RES_W)) u_power (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .x    (x_c),
    .p    (ui_c),
    .acc  (acc),
    .zero (zero)
  );

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    x_d     = x_q;
    ui_d    = ui_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: if (w_start) begin
        x_d     = vi_bus;
        ui_d    = ui_bus;
        c_d     = '0;
        state_d = LOAD;
      end
      LOAD: begin
        load    = 1'b1;
        state_d = (ui_c != '0) ? MUL : WRITE;
      end
      MUL: begin
        step = 1'b1;
        if (zero) state_d = WRITE;
      end
      WRITE: if (wr_ack) begin
        if (c_q == CH_W'(CH - 1)) begin
          state_d = DONE;
        end else begin
          c_d     = c_q + 1'b1;
          state_d = LOAD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they line up with it.
    wr_req_d = (state_d == WRITE);
    busy_d   = (state_d != IDLE);
    w_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      c_q      <= '0;
      x_q      <= '0;
      ui_q     <= '0;
      wr_req_q <= 1'b0;
      busy_q   <= 1'b0;
      w_done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      x_q      <= x_d;
      ui_q     <= ui_d;
      wr_req_q <= wr_req_d;
      busy_q   <= busy_d;
      w_done_q <= w_done_d;
    end
  end

  assign wr_req    = wr_req_q;
  assign wr_data   = acc;
  assign wr_ch     = c_q;
  assign busy      = busy_q;
  assign w_done    = w_done_q;
  assign dbg_state = state_q;

endmodule
